// File: rtl/fan_ctrl_multi.sv
// Multi-level fan controller: dwell-filtered, hysteretic level selection from a
// signed temperature stream, sticky over-temperature alarm, duty decode and PWM.
module fan_ctrl_multi #(
   parameter int SENSOR_W  = 8,
   parameter int N_LEVELS  = 4,
   parameter int BASE_T    = 35,
   parameter int STEP_T    = 5,
   parameter int HYST      = 5,
   parameter int DWELL     = 3,
   parameter int ALARM_T   = 60,
   parameter int DUTY_W    = 4,
   parameter int DUTY_MIN  = 4,
   parameter int DUTY_STEP = 2,
   localparam int LVL_W    = (N_LEVELS > 2) ? $clog2(N_LEVELS) : 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                sensor_valid,
   input  logic [SENSOR_W-1:0] sensor,
   input  logic                alarm_clr,
   output logic [LVL_W-1:0]    level,
   output logic [DUTY_W-1:0]   duty,
   output logic                pwm_o,
   output logic                alarm_o
);

   localparam int CNT_W    = $clog2(DWELL + 1);
   localparam int DUTY_MAX = (1 << DUTY_W) - 1;
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_LEVELS - 1);

   logic [LVL_W-1:0]    level_q, level_d;
   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic [CNT_W-1:0]    up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
   logic [SENSOR_W-1:0] last_q, last_d;
   logic                alarm_q, alarm_d;
   logic [DUTY_W-1:0]   pwm_cnt_q;
   logic                pwm_q;

   logic signed [31:0] sens_ext, last_ext, up_thr, dn_thr;
   int                 lvl;
   logic               up_q, dn_q, set_alarm;

   assign sens_ext = {{(32-SENSOR_W){sensor[SENSOR_W-1]}}, sensor};
   assign last_ext = {{(32-SENSOR_W){last_q[SENSOR_W-1]}}, last_q};
   assign lvl      = int'(level_q);
   assign up_thr   = BASE_T + lvl * STEP_T;
   assign dn_thr   = BASE_T + (lvl - 1) * STEP_T - HYST;

   assign up_q      = sensor_valid && (level_q != LVL_MAX) && (sens_ext > up_thr);
   assign dn_q      = sensor_valid && (level_q != '0) && (sens_ext < dn_thr);
   assign set_alarm = sensor_valid && (sens_ext >= ALARM_T);

   function automatic logic [DUTY_W-1:0] duty_of(input logic [LVL_W-1:0] l);
      int dv;
      if (l == '0) return '0;
      dv = DUTY_MIN + (int'(l) - 1) * DUTY_STEP;
      if (dv > DUTY_MAX) dv = DUTY_MAX;
      return DUTY_W'(dv);
   endfunction

   always_comb begin
      level_d  = level_q;
      up_cnt_d = up_cnt_q;
      dn_cnt_d = dn_cnt_q;
      alarm_d  = alarm_q;
      last_d   = sensor_valid ? sensor : last_q;
      // Set dominates a same-cycle clear; while alarmed, level is pinned and counters idle.
      if (set_alarm) begin
         alarm_d  = 1'b1;
         level_d  = LVL_MAX;
         up_cnt_d = '0;
         dn_cnt_d = '0;
      end else if (alarm_q) begin
         level_d  = LVL_MAX;
         up_cnt_d = '0;
         dn_cnt_d = '0;
         if (alarm_clr && (last_ext < ALARM_T)) alarm_d = 1'b0;
      end else if (sensor_valid) begin
         up_cnt_d = '0;
         dn_cnt_d = '0;
         if (up_q) begin
            if (int'(up_cnt_q) + 1 >= DWELL) level_d = level_q + 1'b1;
            else up_cnt_d = CNT_W'(int'(up_cnt_q) + 1);
         end else if (dn_q) begin
            if (int'(dn_cnt_q) + 1 >= DWELL) level_d = level_q - 1'b1;
            else dn_cnt_d = CNT_W'(int'(dn_cnt_q) + 1);
         end
      end
      duty_d = duty_of(level_d);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         level_q   <= '0;
         duty_q    <= '0;
         up_cnt_q  <= '0;
         dn_cnt_q  <= '0;
         last_q    <= '0;
         alarm_q   <= 1'b0;
         pwm_cnt_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         level_q   <= level_d;
         duty_q    <= duty_d;
         up_cnt_q  <= up_cnt_d;
         dn_cnt_q  <= dn_cnt_d;
         last_q    <= last_d;
         alarm_q   <= alarm_d;
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         pwm_q     <= (pwm_cnt_q < duty_q);
      end
   end

   assign level   = level_q;
   assign duty    = duty_q;
   assign pwm_o   = pwm_q;
   assign alarm_o = alarm_q;

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Directed bench for fan_ctrl_multi at default parameters.
module tb_fan_ctrl_multi;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       sensor_valid = 1'b0;
   logic [7:0] sensor = '0;
   logic       alarm_clr = 1'b0;
   logic [1:0] level;
   logic [3:0] duty;
   logic       pwm_o;
   logic       alarm_o;

   int n_chk = 0;
   int n_err = 0;

   fan_ctrl_multi dut (
      .clk(clk), .rstn(rstn), .sensor_valid(sensor_valid), .sensor(sensor),
      .alarm_clr(alarm_clr), .level(level), .duty(duty), .pwm_o(pwm_o), .alarm_o(alarm_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // One clock with the given inputs; outputs are observed 1 time unit after the edge.
   task automatic step(input logic v, input int s, input logic c);
      sensor_valid = v;
      sensor       = 8'(s);
      alarm_clr    = c;
      @(posedge clk);
      #1;
      sensor_valid = 1'b0;
      alarm_clr    = 1'b0;
   endtask

   task automatic samples(input int s, input int n);
      for (int i = 0; i < n; i++) step(1'b1, s, 1'b0);
   endtask

   task automatic lvl_is(input string tag, input int l, input int d, input int a);
      chk({tag, "_lvl"}, int'(level), l);
      chk({tag, "_duty"}, int'(duty), d);
      chk({tag, "_alarm"}, int'(alarm_o), a);
   endtask

   task automatic pwm_count(input string tag, input int exp);
      int hi;
      hi = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         hi += int'(pwm_o);
      end
      chk(tag, hi, exp);
   endtask

   initial begin
      #12;
      lvl_is("rst", 0, 0, 0);
      chk("rst_pwm", int'(pwm_o), 0);
      rstn = 1'b1;
      step(1'b0, 0, 1'b0);
      pwm_count("pwm_lvl0", 0);

      // 1: ramp with 50
      samples(50, 2);  lvl_is("ramp2", 0, 0, 0);
      samples(50, 1);  lvl_is("ramp3", 1, 4, 0);
      samples(50, 2);  lvl_is("ramp5", 1, 4, 0);
      samples(50, 1);  lvl_is("ramp6", 2, 6, 0);
      samples(50, 3);  lvl_is("ramp9", 3, 8, 0);
      samples(50, 3);  lvl_is("ramp12", 3, 8, 0);

      // 6a: PWM at duty 8
      pwm_count("pwm_lvl3", 8);

      // 3: hysteresis descending
      samples(40, 5);  lvl_is("hold40", 3, 8, 0);
      samples(39, 2);  lvl_is("dn39_2", 3, 8, 0);
      samples(39, 1);  lvl_is("dn39_3", 2, 6, 0);
      samples(34, 3);  lvl_is("dn34", 1, 4, 0);
      samples(32, 10); lvl_is("hold32", 1, 4, 0);
      samples(29, 2);  lvl_is("dn29_2", 1, 4, 0);
      samples(29, 1);  lvl_is("dn29_3", 0, 0, 0);

      // 2: dwell filter broken by a cool sample
      samples(36, 2); samples(20, 1); samples(36, 2);
      lvl_is("dwell_brk", 0, 0, 0);
      samples(36, 1);  lvl_is("dwell_ok", 1, 4, 0);
      samples(29, 3);  lvl_is("back0a", 0, 0, 0);

      // 5: invalid cycles neither advance nor clear the dwell count
      samples(36, 1);
      for (int i = 0; i < 5; i++) step(1'b0, 99, 1'b0);
      samples(36, 1);  lvl_is("gap2", 0, 0, 0);
      samples(36, 1);  lvl_is("gap3", 1, 4, 0);
      samples(29, 3);  lvl_is("back0b", 0, 0, 0);
      samples(-10, 4); lvl_is("neg", 0, 0, 0);

      // 4: alarm
      samples(60, 1);  lvl_is("alm_set", 3, 8, 1);
      samples(65, 1);
      step(1'b0, 0, 1'b1); lvl_is("alm_clr_ign", 3, 8, 1);
      samples(50, 1);
      step(1'b0, 0, 1'b1); lvl_is("alm_clr_ok", 3, 8, 0);
      step(1'b1, 70, 1'b1); lvl_is("alm_set_wins", 3, 8, 1);
      samples(50, 1);
      step(1'b0, 0, 1'b1); lvl_is("alm_clr2", 3, 8, 0);
      samples(39, 3);  lvl_is("alm_desc", 2, 6, 0);

      // 6b: async reset mid-ramp discards the partial dwell count
      samples(29, 9);  lvl_is("pre_rst", 0, 0, 0);
      samples(50, 6);  lvl_is("ramp_b", 2, 6, 0);
      samples(50, 2);
      #2;
      rstn = 1'b0;
      #1;
      lvl_is("mid_rst", 0, 0, 0);
      chk("mid_rst_pwm", int'(pwm_o), 0);
      #3;
      rstn = 1'b1;
      samples(50, 2);  lvl_is("rst_ramp2", 0, 0, 0);
      samples(50, 1);  lvl_is("rst_ramp3", 1, 4, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
